// File: rtl/yd_dbus_arb.sv
// yd_dbus_arb: two-master data-bus arbiter with burst-limited ownership.
// Define YD_DBUS_ARB_RR_EN to resolve IDLE ties round-robin; otherwise m0 has fixed priority.
module yd_dbus_arb #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_din,
    input  logic [DW-1:0] m1_din,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_din,
    output logic          d_we,
    input  logic [DW-1:0] d_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] LIM = 4'(BURST - 1);

    state_t     state;
    state_t     own;
    logic [3:0] cnt;
    logic       win;
    logic       w;
    logic       lt;
    logic       tie_w;

`ifdef YD_DBUS_ARB_RR_EN
    logic       last;
    assign tie_w = ~last;
`else
    assign tie_w = 1'b0;
`endif

    // Winner select: the owner keeps the bus until its burst budget runs out while the other waits
    always_comb begin
        lt     = cnt < LIM;
        win    = m0_req | m1_req;
        w      = (state == OWN0) ? ~(m0_req & (~m1_req | lt)) :
                 (state == OWN1) ? (~m0_req | (m1_req & lt)) :
                 (m0_req & m1_req) ? tie_w : m1_req;
        own    = w ? OWN1 : OWN0;
        m0_gnt = win & ~w;
        m1_gnt = win & w;
        d_addr = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
        d_din  = m1_gnt ? m1_din : m0_gnt ? m0_din : '0;
        d_we   = m1_gnt ? m1_we : m0_gnt ? m0_we : 1'b0;
    end

    // Memory returns data one cycle after the address, so read data passes straight through
    assign m0_rdata = m0_rvalid ? d_dout : '0;
    assign m1_rdata = m1_rvalid ? d_dout : '0;

    // Owner FSM, beat counter and read-return tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
`ifdef YD_DBUS_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            state     <= win ? own : IDLE;
            cnt       <= (win && state == own) ? ((cnt == 4'hF) ? cnt : cnt + 4'd1) : '0;
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
`ifdef YD_DBUS_ARB_RR_EN
            last      <= win ? w : last;
`endif
        end
    end

endmodule

// File: tb/tb_yd_dbus_arb.sv
// tb_yd_dbus_arb: scoreboard bench for yd_dbus_arb (BURST=4 instance A, BURST=1 instance B).
module tb_yd_dbus_arb;

    localparam logic [15:0] K = 16'h5A3C;

    typedef struct packed {
        logic        t;
        logic        g0;
        logic        g1;
        logic [15:0] a;
        logic [15:0] d;
        logic        we;
    } gexp_t;

    typedef struct packed {
        logic        t;
        logic        v0;
        logic        v1;
        logic [15:0] r0;
        logic [15:0] r1;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a0_req = 0, a1_req = 0, a0_we = 0, a1_we = 0;
    logic [15:0] a0_addr = 0, a1_addr = 0, a0_din = 0, a1_din = 0;
    logic        ag0, ag1, av0, av1, ad_we;
    logic [15:0] ar0, ar1, ad_addr, ad_din;
    logic [15:0] ad_dout = 0;

    logic        b0_req = 0, b1_req = 0, b0_we = 0, b1_we = 0;
    logic [15:0] b0_addr = 0, b1_addr = 0, b0_din = 0, b1_din = 0;
    logic        bg0, bg1, bv0, bv1, bd_we;
    logic [15:0] br0, br1, bd_addr, bd_din;
    logic [15:0] bd_dout = 0;

    gexp_t qg[$];
    rexp_t qr[$];
    int    cmp = 0;
    int    bad = 0;

    yd_dbus_arb #(.DW(16), .AW(16), .BURST(4)) u_a (
        .clk(clk), .rst(rst),
        .m0_req(a0_req), .m1_req(a1_req), .m0_we(a0_we), .m1_we(a1_we),
        .m0_addr(a0_addr), .m1_addr(a1_addr), .m0_din(a0_din), .m1_din(a1_din),
        .m0_gnt(ag0), .m1_gnt(ag1), .m0_rvalid(av0), .m1_rvalid(av1),
        .m0_rdata(ar0), .m1_rdata(ar1),
        .d_addr(ad_addr), .d_din(ad_din), .d_we(ad_we), .d_dout(ad_dout)
    );

    yd_dbus_arb #(.DW(16), .AW(16), .BURST(1)) u_b (
        .clk(clk), .rst(rst),
        .m0_req(b0_req), .m1_req(b1_req), .m0_we(b0_we), .m1_we(b1_we),
        .m0_addr(b0_addr), .m1_addr(b1_addr), .m0_din(b0_din), .m1_din(b1_din),
        .m0_gnt(bg0), .m1_gnt(bg1), .m0_rvalid(bv0), .m1_rvalid(bv1),
        .m0_rdata(br0), .m1_rdata(br1),
        .d_addr(bd_addr), .d_din(bd_din), .d_we(bd_we), .d_dout(bd_dout)
    );

    // Memory model: data for an address appears one cycle later
    always @(posedge clk) begin
        ad_dout <= ad_addr ^ K;
        bd_dout <= bd_addr ^ K;
    end

    // Monitor: pop and compare whenever a grant or read-valid is presented
    always @(negedge clk) begin
        gexp_t o, e;
        rexp_t ro, re;
        if (ag0 | ag1 | bg0 | bg1) begin
            o = (ag0 | ag1) ? gexp_t'({1'b0, ag0, ag1, ad_addr, ad_din, ad_we})
                            : gexp_t'({1'b1, bg0, bg1, bd_addr, bd_din, bd_we});
            cmp++;
            if (qg.size() == 0) begin
                bad++;
                $display("FAIL grant: got %h, required none", o);
            end else begin
                e = qg.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL grant: got %h, required %h", o, e);
                end
            end
        end
        if (!(ag0 | ag1)) begin
            cmp++;
            if ({ad_addr, ad_din, ad_we} !== 33'h0) begin
                bad++;
                $display("FAIL idle_bus_a: got %h/%h/%b, required 0/0/0", ad_addr, ad_din, ad_we);
            end
        end
        if (!(bg0 | bg1)) begin
            cmp++;
            if ({bd_addr, bd_din, bd_we} !== 33'h0) begin
                bad++;
                $display("FAIL idle_bus_b: got %h/%h/%b, required 0/0/0", bd_addr, bd_din, bd_we);
            end
        end
        if (av0 | av1 | bv0 | bv1) begin
            ro = (av0 | av1) ? rexp_t'({1'b0, av0, av1, ar0, ar1})
                             : rexp_t'({1'b1, bv0, bv1, br0, br1});
            cmp++;
            if (qr.size() == 0) begin
                bad++;
                $display("FAIL rvalid: got %h, required none", ro);
            end else begin
                re = qr.pop_front();
                if (ro !== re) begin
                    bad++;
                    $display("FAIL rvalid: got %h, required %h", ro, re);
                end
            end
        end else if ({ar0, ar1, br0, br1} !== 64'h0) begin
            cmp++;
            bad++;
            $display("FAIL rdata_idle: got %h, required 0", {ar0, ar1, br0, br1});
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", n, got, exp);
        end
    endtask

    // One cycle of stimulus on instance t with the hand-computed winner (e0/e1)
    task automatic step(input bit t,
                        input logic r0, input logic w0, input logic [15:0] x0, input logic [15:0] y0,
                        input logic r1, input logic w1, input logic [15:0] x1, input logic [15:0] y1,
                        input logic e0, input logic e1, input bit rd = 1'b1);
        {a0_req, a0_we, a0_addr, a0_din, a1_req, a1_we, a1_addr, a1_din} = '0;
        {b0_req, b0_we, b0_addr, b0_din, b1_req, b1_we, b1_addr, b1_din} = '0;
        if (!t) {a0_req, a0_we, a0_addr, a0_din, a1_req, a1_we, a1_addr, a1_din} = {r0, w0, x0, y0, r1, w1, x1, y1};
        else    {b0_req, b0_we, b0_addr, b0_din, b1_req, b1_we, b1_addr, b1_din} = {r0, w0, x0, y0, r1, w1, x1, y1};
        if (e0 | e1)
            qg.push_back(gexp_t'({t, e0, e1, e1 ? x1 : x0, e1 ? y1 : y0, e1 ? w1 : w0}));
        if (rd && ((e0 && !w0) || (e1 && !w1)))
            qr.push_back(rexp_t'({t, e0, e1, e0 ? (x0 ^ K) : 16'h0, e1 ? (x1 ^ K) : 16'h0}));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", {28'h0, av0, av1, bv0, bv1}, 32'h0);
        rst = 1'b1;
        // single m0 read
        step(1'b0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0);
        idle();
        // m1 write while m0 is idle
        step(1'b0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0200, 16'hBEEF, 0, 1);
        idle();
        // continuous contention with BURST=4
        for (int i = 0; i < 9; i++)
            step(1'b0, 1, 0, 16'h0100, 16'h1111, 1, 0, 16'h0300, 16'h2222,
                 (i < 4) || (i == 8), (i >= 4) && (i < 8));
        idle();
        // IDLE tie after m0 owned last
`ifdef YD_DBUS_ARB_RR_EN
        step(1'b0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0030, 16'h0, 0, 1);
`else
        step(1'b0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0030, 16'h0, 1, 0);
`endif
        idle();
        // reset one cycle after a granted m1 read
        step(1'b0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0404, 16'h0, 0, 1, 1'b0);
        {a1_req, a1_addr} = '0;
        rst = 1'b0;
        #1;
        chk("rst_drops_rvalid", {31'h0, av1}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1, 0, 16'h0500, 16'h0, 1, 0, 16'h0600, 16'h0, 1, 0);
        idle();
        // BURST=1 alternation on instance B
        for (int i = 0; i < 6; i++)
            step(1'b1, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0080, 16'h0, (i % 2) == 0, (i % 2) == 1);
        idle();
        idle();
        chk("grant_queue_empty", qg.size(), 32'h0);
        chk("read_queue_empty", qr.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/yd_dbus_arb.md
YD_DBUS_ARB -- requirements
Module: yd_dbus_arb

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning data width.
REQ-002 The block SHALL have parameter AW, default 16, meaning address width.
REQ-003 The block SHALL have parameter BURST, default 4, legal range 1..15, meaning the maximum consecutive beats an owner keeps while the other master requests.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports m0_req/m1_req, input, 1 bit each: access request; m0 is the core, m1 is the loader/debug master.
REQ-007 The block SHALL have ports m0_we/m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_addr/m1_addr, input, AW bits each: access address.
REQ-009 The block SHALL have ports m0_din/m1_din, input, DW bits each: write data.
REQ-010 The block SHALL have ports m0_gnt/m1_gnt, output, 1 bit each: access accepted this cycle.
REQ-011 The block SHALL have ports m0_rvalid/m1_rvalid, output, 1 bit each: read data valid.
REQ-012 The block SHALL have ports m0_rdata/m1_rdata, output, DW bits each: read data.
REQ-013 The block SHALL have port d_addr, output, AW bits: memory address.
REQ-014 The block SHALL have port d_din, output, DW bits: memory write data.
REQ-015 The block SHALL have port d_we, output, 1 bit: memory write enable, active-high.
REQ-016 The block SHALL have port d_dout, input, DW bits: memory read data, valid one cycle after the address.

Function
REQ-017 The block SHALL use an owner FSM with states IDLE, OWN0 and OWN1, plus a 4-bit beat counter cnt.
REQ-018 Each cycle the block SHALL select a winner W combinationally from the current requests, the FSM state and cnt.
REQ-019 In OWNx, W SHALL be x if mx_req=1 and (the other master's req=0 or cnt<BURST-1); otherwise W SHALL be the other master if it requests; otherwise there SHALL be no winner.
REQ-020 In IDLE, a single requester SHALL win; for simultaneous requests, the tie SHALL be resolved per REQ-031/REQ-032.
REQ-021 mW_gnt SHALL be 1 in the same cycle; the losing gnt SHALL be 0; gnt SHALL never be 1 without req.
REQ-022 d_addr, d_din and d_we SHALL equal mW_addr, mW_din and mW_we; with no winner they SHALL be 0, 0 and 0.
REQ-023 Next state SHALL be OWNW; with no winner, next state SHALL be IDLE.
REQ-024 Next cnt SHALL be cnt+1, saturating at 15, if W equals the previous owner; otherwise cnt SHALL be 0.
REQ-025 A granted read (mW_we=0) SHALL assert mW_rvalid for exactly one cycle, on the next cycle, with mW_rdata=d_dout.
REQ-026 When rvalid=0, rdata SHALL be 0; granted writes SHALL produce no rvalid.
REQ-027 Back-to-back grants SHALL be allowed; a grant on the cycle of another master's rvalid SHALL be legal; throughput SHALL be 1 access per cycle.
REQ-028 With BURST=1, the grant SHALL alternate every cycle while both masters request.

Reset
REQ-029 While rst=0, state SHALL be IDLE, cnt SHALL be 0, both rvalid SHALL be 0, and the last-owner flag SHALL be 1 so m0 wins the first tie.
REQ-030 Assertion of rst in the middle of a read SHALL drop the pending rvalid; outputs SHALL follow REQ-021/REQ-022 combinationally from the reset state.

Configuration
REQ-031 With macro YD_DBUS_ARB_RR_EN defined, an IDLE tie SHALL grant the master that did not own the bus last; the last-owner flag SHALL update on every grant.
REQ-032 Without YD_DBUS_ARB_RR_EN, an IDLE tie SHALL always grant m0 (fixed priority); the last-owner flag SHALL be absent. Burst preemption (REQ-019) SHALL apply in both builds.

Verification
REQ-033 After reset, m0 read addr 0x0010 alone -> m0_gnt=1 same cycle, d_addr=0x0010, d_we=0; next cycle m0_rvalid=1, m0_rdata=d_dout.
REQ-034 BURST=4, both masters request continuously from IDLE -> grants m0,m0,m0,m0,m1,m1,m1,m1,m0...; cnt resets on each switch.
REQ-035 m1 write addr 0x0200, data 0xBEEF while m0 is idle -> d_we=1, d_din=0xBEEF, m1_gnt=1, no rvalid on either master.
REQ-036 Simultaneous requests from IDLE after an m0-owned access, with RR_EN defined -> m1 wins; without RR_EN -> m0 wins.
REQ-037 rst driven low one cycle after a granted m1 read -> m1_rvalid=0 immediately and state=IDLE; after release, the first m0 request is granted.
REQ-038 BURST=1, both masters request for 6 cycles -> gnt alternates m0,m1,m0,m1,m0,m1; each read returns rvalid to the correct master one cycle later.
